// File: rtl/usb_rob.sv
// usb_rob: reorder buffer between the USB request arbiter and the CPU NOC.
// Optional head-entry timeout enabled with `define USB_ROB_TIMEOUT_EN.
package usb_rob_pkg;
  localparam int TID_W = 6;

  typedef struct packed {
    logic [1:0]       cpu_noc_id;
    logic [1:0]       src;
    logic [TID_W-1:0] tid;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic [31:0]       data;
    logic [3:0]        mask;
    cpu_cache_if_tid_t req_tid;
  } cpu_cache_if_req_t;

  typedef struct packed {
    logic [31:0]       resp_data;
    logic [3:0]        resp_mask;
    cpu_cache_if_tid_t resp_tid;
  } cpu_cache_if_resp_t;
endpackage

module usb_rob
  import usb_rob_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               up_req_valid,
  input  cpu_cache_if_req_t  up_req,
  output logic               up_req_ready,
  output logic               up_resp_valid,
  output cpu_cache_if_resp_t up_resp,
  input  logic               up_resp_ready,
  output logic               noc_req_valid,
  output cpu_cache_if_req_t  noc_req,
  input  logic               noc_req_ready,
  input  logic               noc_resp_valid,
  input  cpu_cache_if_resp_t noc_resp,
  output logic               noc_resp_ready,
  output logic               rob_empty,
  output logic               rob_err
);

  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d;
  cpu_cache_if_tid_t tid_q [DEPTH];
  cpu_cache_if_tid_t tid_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [3:0]  mask_q [DEPTH];
  logic [3:0]  mask_d [DEPTH];
  logic rv_q, rv_d, err_q, err_d, run_q;

  logic [IDX_W-1:0] hidx, tidx, cidx;
  logic empty, full, req_fire, cap, cap_ok, rel, tmo;

  assign hidx = head_q[IDX_W-1:0];
  assign tidx = tail_q[IDX_W-1:0];
  assign cidx = noc_resp.resp_tid.tid[IDX_W-1:0];

  assign empty = head_q == tail_q;
  assign full  = (hidx == tidx) & (head_q[IDX_W] != tail_q[IDX_W]);

  assign up_req_ready   = run_q & noc_req_ready & ~full;
  assign noc_req_valid  = run_q & up_req_valid & ~full;
  assign noc_resp_ready = run_q;
  assign up_resp_valid  = rv_q;
  assign rob_empty      = empty;
  assign rob_err        = err_q;

  assign req_fire = up_req_valid & up_req_ready;
  assign cap      = noc_resp_valid & run_q;
  assign cap_ok   = cap & alloc_q[cidx] & ~done_q[cidx];
  assign rel      = rv_q & up_resp_ready;

  logic unused_ok;
  assign unused_ok = ^{noc_resp.resp_tid, 32'(TIMEOUT_CYC)};

  // retag the outgoing request with its slot index
  always_comb begin
    noc_req             = up_req;
    noc_req.req_tid.tid = TID_W'(tidx);
  end

  // present the head slot with its original tid restored
  always_comb begin
    up_resp           = '0;
    up_resp.resp_data = data_q[hidx];
    up_resp.resp_mask = mask_q[hidx];
    up_resp.resp_tid  = tid_q[hidx];
  end

  // slot allocation, response capture and in-order release
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    done_d  = done_q;
    tid_d   = tid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (req_fire) begin
      alloc_d[tidx] = 1'b1;
      done_d[tidx]  = 1'b0;
      tid_d[tidx]   = up_req.req_tid;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (cap_ok) begin
      done_d[cidx] = 1'b1;
      data_d[cidx] = noc_resp.resp_data;
      mask_d[cidx] = noc_resp.resp_mask;
    end
    if (rel) begin
      alloc_d[hidx] = 1'b0;
      done_d[hidx]  = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (rv_q) begin
      rv_d = ~up_resp_ready;
    end else begin
      rv_d = alloc_q[hidx]
           & (done_q[hidx] | (cap_ok & (cidx == hidx)));
    end
    err_d = err_q | (cap & ~cap_ok) | tmo;
  end

`ifdef USB_ROB_TIMEOUT_EN
  logic [15:0] age_q, age_d;

  // age of an outstanding head entry, saturating at the deadline
  always_comb begin
    age_d = age_q;
    tmo   = age_q == 16'(TIMEOUT_CYC);
    if (rel | empty) begin
      age_d = '0;
    end else if (alloc_q[hidx] & ~done_q[hidx] & ~tmo) begin
      age_d = age_q + 16'd1;
    end
  end

  // head-age register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) age_q <= '0;
    else       age_q <= age_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tid_q[i]  <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
      tid_q   <= tid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_usb_rob.sv
// tb_usb_rob: directed table and sequence checks for usb_rob.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_usb_rob;
  import usb_rob_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic up_req_valid, up_req_ready;
  cpu_cache_if_req_t up_req, noc_req;
  logic up_resp_valid, up_resp_ready;
  cpu_cache_if_resp_t up_resp, noc_resp;
  logic noc_req_valid, noc_req_ready;
  logic noc_resp_valid, noc_resp_ready;
  logic rob_empty, rob_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usb_rob dut (
    .clk(clk), .rstn(rstn),
    .up_req_valid(up_req_valid), .up_req(up_req),
    .up_req_ready(up_req_ready),
    .up_resp_valid(up_resp_valid), .up_resp(up_resp),
    .up_resp_ready(up_resp_ready),
    .noc_req_valid(noc_req_valid), .noc_req(noc_req),
    .noc_req_ready(noc_req_ready),
    .noc_resp_valid(noc_resp_valid), .noc_resp(noc_resp),
    .noc_resp_ready(noc_resp_ready),
    .rob_empty(rob_empty), .rob_err(rob_err)
  );

  typedef struct {
    logic        rqv;
    logic [5:0]  rtid;
    logic        rsv;
    logic [2:0]  rslot;
    logic [31:0] rdata;
    logic        urdy;
    logic [5:0]  e_ntid;
    logic        e_uv;
    logic [5:0]  e_utid;
    logic [31:0] e_udata;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rqv, logic [5:0] rtid, logic rsv, logic [2:0] rslot,
    logic [31:0] rdata, logic urdy, logic [5:0] e_ntid,
    logic e_uv, logic [5:0] e_utid, logic [31:0] e_udata,
    logic e_empty);
    vec_t v;
    v.rqv = rqv; v.rtid = rtid; v.rsv = rsv; v.rslot = rslot;
    v.rdata = rdata; v.urdy = urdy; v.e_ntid = e_ntid;
    v.e_uv = e_uv; v.e_utid = e_utid; v.e_udata = e_udata;
    v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rqv, input logic [5:0] rtid,
                       input logic rsv, input logic [2:0] rslot,
                       input logic [31:0] rdata, input logic urdy);
    up_req_valid         = rqv;
    up_req               = '0;
    up_req.addr          = 32'h1000 + 32'(rtid);
    up_req.we            = 1'b1;
    up_req.data          = 32'hD000 + 32'(rtid);
    up_req.mask          = 4'hF;
    up_req.req_tid       = '{cpu_noc_id: 2'd1, src: 2'd2, tid: rtid};
    noc_resp_valid       = rsv;
    noc_resp             = '0;
    noc_resp.resp_data   = rdata;
    noc_resp.resp_mask   = 4'h5;
    noc_resp.resp_tid.tid = {3'b000, rslot};
    up_resp_ready        = urdy;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.rqv, v.rtid, v.rsv, v.rslot, v.rdata, v.urdy);
    #1;
    chk({tag, " rdy"}, 32'(up_req_ready), 32'd1);
    if (v.rqv) begin
      chk({tag, " nvld"}, 32'(noc_req_valid), 32'd1);
      chk({tag, " ntid"}, 32'(noc_req.req_tid.tid), 32'(v.e_ntid));
      chk({tag, " nsrc"}, 32'(noc_req.req_tid.src), 32'd2);
      chk({tag, " naddr"}, noc_req.addr, 32'h1000 + 32'(v.rtid));
    end
    chk({tag, " uv"}, 32'(up_resp_valid), 32'(v.e_uv));
    if (v.e_uv) begin
      chk({tag, " utid"}, 32'(up_resp.resp_tid.tid), 32'(v.e_utid));
      chk({tag, " usrc"}, 32'(up_resp.resp_tid.src), 32'd2);
      chk({tag, " udata"}, up_resp.resp_data, v.e_udata);
    end
    chk({tag, " empty"}, 32'(rob_empty), 32'(v.e_empty));
    chk({tag, " err"}, 32'(rob_err), 32'd0);
  endtask

  initial begin
    noc_req_ready = 1'b1;
    rstn = 1'b0;
    idle();
    up_req_valid = 1'b1;
    #1;
    chk("rst rdy", 32'(up_req_ready), 32'd0);
    chk("rst nvld", 32'(noc_req_valid), 32'd0);
    chk("rst nrrdy", 32'(noc_resp_ready), 32'd0);
    chk("rst uv", 32'(up_resp_valid), 32'd0);
    chk("rst empty", 32'(rob_empty), 32'd1);
    chk("rst err", 32'(rob_err), 32'd0);
    do_reset();

    // in-order flow
    vecs.push_back(mk(1, 6'h05, 0, 0, 0,     0, 0, 0, 0,     0,     1));
    vecs.push_back(mk(1, 6'h06, 0, 0, 0,     0, 1, 0, 0,     0,     0));
    vecs.push_back(mk(1, 6'h07, 1, 0, 32'hA, 0, 2, 0, 0,     0,     0));
    vecs.push_back(mk(0, 0,     1, 1, 32'hB, 1, 0, 1, 6'h05, 32'hA, 0));
    vecs.push_back(mk(0, 0,     1, 2, 32'hC, 1, 0, 0, 0,     0,     0));
    vecs.push_back(mk(0, 0,     0, 0, 0,     1, 0, 1, 6'h06, 32'hB, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,     1, 0, 0, 0,     0,     0));
    vecs.push_back(mk(0, 0,     0, 0, 0,     1, 0, 1, 6'h07, 32'hC, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0,     0, 0, 0, 0,     0,     1));
    // reorder: base slot 3, responses to relative slots 3,1,0,2
    vecs.push_back(mk(1, 6'h10, 0, 0, 0,       0, 3, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6'h11, 0, 0, 0,       0, 4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6'h12, 0, 0, 0,       0, 5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6'h13, 0, 0, 0,       0, 6, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 6, 32'h103, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 4, 32'h101, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 3, 32'h100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 32'h102, 1, 0, 1, 6'h10, 32'h100, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 0, 0,     0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 1, 6'h11, 32'h101, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 0, 0,     0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 1, 6'h12, 32'h102, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 0, 0,     0,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 0, 1, 6'h13, 32'h103, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0, 0,     0,       1));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 6'h20 + 6'(i), 1'b0, 3'd0, 32'd0, 1'b0);
      #1;
      chk($sformatf("fill%0d rdy", i), 32'(up_req_ready), 32'd1);
      chk($sformatf("fill%0d ntid", i),
          32'(noc_req.req_tid.tid), i);
    end
    @(negedge clk);
    drive(1'b1, 6'h28, 1'b1, 3'd0, 32'hF0, 1'b0);
    #1;
    chk("full rdy", 32'(up_req_ready), 32'd0);
    chk("full nvld", 32'(noc_req_valid), 32'd0);
    chk("full empty", 32'(rob_empty), 32'd0);
    @(negedge clk);
    drive(1'b1, 6'h28, 1'b0, 3'd0, 32'd0, 1'b1);
    #1;
    chk("full rel uv", 32'(up_resp_valid), 32'd1);
    chk("full rel tid", 32'(up_resp.resp_tid.tid), 32'h20);
    chk("full rel data", up_resp.resp_data, 32'hF0);
    chk("full rel rdy", 32'(up_req_ready), 32'd0);
    @(negedge clk);
    drive(1'b1, 6'h28, 1'b0, 3'd0, 32'd0, 1'b0);
    #1;
    chk("wrap rdy", 32'(up_req_ready), 32'd1);
    chk("wrap nvld", 32'(noc_req_valid), 32'd1);
    chk("wrap ntid", 32'(noc_req.req_tid.tid), 32'd0);

    // backpressure with head done
    @(negedge clk);
    drive(1'b0, 6'd0, 1'b1, 3'd1, 32'hB1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) drive(1'b0, 6'd0, 1'b1, 3'd2, 32'hB2, 1'b0);
      else        idle();
      #1;
      chk($sformatf("bp%0d uv", i), 32'(up_resp_valid), 32'd1);
      chk($sformatf("bp%0d tid", i),
          32'(up_resp.resp_tid.tid), 32'h21);
      chk($sformatf("bp%0d data", i), up_resp.resp_data, 32'hB1);
    end
    @(negedge clk);
    drive(1'b0, 6'd0, 1'b0, 3'd0, 32'd0, 1'b1);
    #1;
    chk("bp rel uv", 32'(up_resp_valid), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("bp gap uv", 32'(up_resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("bp next uv", 32'(up_resp_valid), 32'd1);
    chk("bp next tid", 32'(up_resp.resp_tid.tid), 32'h22);
    chk("bp next data", up_resp.resp_data, 32'hB2);
    chk("bp err", 32'(rob_err), 32'd0);

    // unallocated response
    do_reset();
    @(negedge clk);
    drive(1'b0, 6'd0, 1'b1, 3'd6, 32'hEE, 1'b0);
    #1;
    chk("err pre", 32'(rob_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("err%0d err", i), 32'(rob_err), 32'd1);
      chk($sformatf("err%0d uv", i), 32'(up_resp_valid), 32'd0);
      chk($sformatf("err%0d empty", i), 32'(rob_empty), 32'd1);
    end

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 6'h30 + 6'(i), 1'b0, 3'd0, 32'd0, 1'b0);
      #1;
      chk($sformatf("mid%0d ntid", i), 32'(noc_req.req_tid.tid), i);
    end
    @(negedge clk);
    drive(1'b1, 6'h33, 1'b0, 3'd0, 32'd0, 1'b0);
    #1;
    chk("mid empty", 32'(rob_empty), 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("arst rdy", 32'(up_req_ready), 32'd0);
    chk("arst nvld", 32'(noc_req_valid), 32'd0);
    chk("arst nrrdy", 32'(noc_resp_ready), 32'd0);
    chk("arst uv", 32'(up_resp_valid), 32'd0);
    chk("arst empty", 32'(rob_empty), 32'd1);
    chk("arst err", 32'(rob_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 6'h34, 1'b0, 3'd0, 32'd0, 1'b0);
    #1;
    chk("post rdy", 32'(up_req_ready), 32'd1);
    chk("post nrrdy", 32'(noc_resp_ready), 32'd1);
    chk("post ntid", 32'(noc_req.req_tid.tid), 32'd0);
    @(negedge clk);
    drive(1'b0, 6'd0, 1'b1, 3'd1, 32'h77, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk("late err", 32'(rob_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
